// File: rtl/decrement_timer_nbit.sv
// rtl/decrement_timer_nbit.sv - loadable step-programmable down-counter/timer with run-mode FSM
//
// Ports:
//   clk       rising-edge clock for all state
//   rst       synchronous active-high reset
//   load      capture load_val into count and reload register, return to IDLE
//   load_val  value captured on load
//   start     IDLE/DONE -> RUN, latches mode (11 treated as one-shot)
//   stop      RUN -> IDLE, count held
//   en        qualifies one decrement step per cycle while running
//   step      unsigned amount subtracted per enabled cycle
//   mode      00 one-shot, 01 auto-reload, 10 wrap, 11 one-shot
//   count     registered current count
//   tc        registered one-cycle terminal-count pulse
//   done      high while in DONE (one-shot expired)
//   busy      high while in RUN
//   zero      count register equals zero

module decrement_timer_nbit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic [WIDTH-1:0] step,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic             busy,
    output logic             zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;
    localparam logic [1:0] MODE_WRAP    = 2'b10;

    state_t           state, state_n;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] reload_reg, reload_n;
    logic [1:0]       mode_reg, mode_n;
    logic             tc_n;

    // One extra bit on the subtraction so the MSB is the borrow.
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             step_nz;
    logic             boundary;

    assign diff     = {1'b0, count} - {1'b0, step};
    assign borrow   = diff[WIDTH];
    assign step_nz  = (step != '0);
    // A zero step never reaches a boundary, even from count==0.
    assign boundary = step_nz && (borrow || (diff[WIDTH-1:0] == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            count      <= '0;
            reload_reg <= '0;
            mode_reg   <= MODE_ONESHOT;
            tc         <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            reload_reg <= reload_n;
            mode_reg   <= mode_n;
            tc         <= tc_n;
        end
    end

    // Priority: load > stop > start > en. stop only acts in RUN and start
    // only outside RUN, so an inert command falls through to the next one.
    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload_reg;
        mode_n   = mode_reg;
        tc_n     = 1'b0;

        if (load) begin
            count_n  = load_val;
            reload_n = load_val;
            state_n  = ST_IDLE;
        end else if (stop && (state == ST_RUN)) begin
            state_n = ST_IDLE;
        end else if (start && (state != ST_RUN)) begin
            state_n = ST_RUN;
            mode_n  = (mode == 2'b11) ? MODE_ONESHOT : mode;
        end else if ((state == ST_RUN) && en && step_nz) begin
            case (mode_reg)
                MODE_WRAP: begin
                    // Modulo arithmetic; only a true underflow is a terminal count.
                    count_n = diff[WIDTH-1:0];
                    tc_n    = borrow;
                end
                MODE_RELOAD: begin
                    if (boundary) begin
                        count_n = reload_reg;
                        tc_n    = 1'b1;
                    end else begin
                        count_n = diff[WIDTH-1:0];
                    end
                end
                default: begin
                    // One-shot saturates at zero instead of underflowing.
                    if (boundary) begin
                        count_n = '0;
                        state_n = ST_DONE;
                        tc_n    = 1'b1;
                    end else begin
                        count_n = diff[WIDTH-1:0];
                    end
                end
            endcase
        end
    end

    assign done = (state == ST_DONE);
    assign busy = (state == ST_RUN);
    assign zero = (count == '0);

endmodule

// File: tb/tb_decrement_timer_nbit.sv
// tb/tb_decrement_timer_nbit.sv - scoreboard bench for decrement_timer_nbit

module tb_decrement_timer_nbit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, load, start, stop, en;
    logic [W-1:0] load_val, step;
    logic [1:0]   mode;
    logic [W-1:0] count;
    logic         tc, done, busy, zero;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string        tag;
        logic [W-1:0] cnt;
        logic         tc;
        logic         busy;
        logic         done;
        logic         zero;
    } exp_t;

    exp_t sb[$];

    decrement_timer_nbit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .en       (en),
        .step     (step),
        .mode     (mode),
        .count    (count),
        .tc       (tc),
        .done     (done),
        .busy     (busy),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, push its expected outcome, then pop and
    // compare once the edge has produced the registered result.
    task automatic cyc(input string tag, input logic r, input logic ld, input logic [W-1:0] lv,
                       input logic st, input logic sp, input logic e, input logic [W-1:0] stp,
                       input logic [1:0] md, input logic [W-1:0] ec, input logic etc,
                       input logic eb, input logic ed);
        exp_t x;
        exp_t got;
        rst = r; load = ld; load_val = lv; start = st; stop = sp; en = e; step = stp; mode = md;
        x.tag = tag; x.cnt = ec; x.tc = etc; x.busy = eb; x.done = ed; x.zero = (ec == '0);
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            check({got.tag, "_count"}, {16'd0, count}, {16'd0, got.cnt});
            check({got.tag, "_tc"},    {31'd0, tc},    {31'd0, got.tc});
            check({got.tag, "_busy"},  {31'd0, busy},  {31'd0, got.busy});
            check({got.tag, "_done"},  {31'd0, done},  {31'd0, got.done});
            check({got.tag, "_zero"},  {31'd0, zero},  {31'd0, got.zero});
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0;
        en = 1'b0; step = '0; mode = 2'b00;
        @(negedge clk);

        //   tag          r  ld lv   st sp en step  md     cnt       tc eb ed
        cyc("reset",      1, 0, 0,   0, 0, 0, 0,    2'b00, 16'd0,    0, 0, 0);

        // reset mid-run
        cyc("rm_load",    0, 1, 100, 0, 0, 0, 1,    2'b01, 16'd100,  0, 0, 0);
        cyc("rm_start",   0, 0, 0,   1, 0, 1, 1,    2'b01, 16'd100,  0, 1, 0);
        for (int i = 1; i <= 10; i++)
            cyc("rm_run", 0, 0, 0,   0, 0, 1, 1,    2'b01, 16'(100 - i), 0, 1, 0);
        cyc("rm_rst",     1, 0, 0,   0, 0, 1, 1,    2'b01, 16'd0,    0, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc("rm_after", 0, 0, 0, 0, 0, 1, 1,    2'b01, 16'd0,    0, 0, 0);

        // one-shot
        cyc("os_load",    0, 1, 5,   0, 0, 0, 2,    2'b00, 16'd5,    0, 0, 0);
        cyc("os_start",   0, 0, 0,   1, 0, 1, 2,    2'b00, 16'd5,    0, 1, 0);
        cyc("os_3",       0, 0, 0,   0, 0, 1, 2,    2'b00, 16'd3,    0, 1, 0);
        cyc("os_1",       0, 0, 0,   0, 0, 1, 2,    2'b00, 16'd1,    0, 1, 0);
        cyc("os_0",       0, 0, 0,   0, 0, 1, 2,    2'b00, 16'd0,    1, 0, 1);
        cyc("os_hold",    0, 0, 0,   0, 0, 1, 2,    2'b00, 16'd0,    0, 0, 1);
        cyc("os_hold",    0, 0, 0,   0, 0, 1, 2,    2'b00, 16'd0,    0, 0, 1);

        // auto-reload
        cyc("ar_load",    0, 1, 4,   0, 0, 0, 1,    2'b01, 16'd4,    0, 0, 0);
        cyc("ar_start",   0, 0, 0,   1, 0, 1, 1,    2'b01, 16'd4,    0, 1, 0);
        for (int p = 0; p < 2; p++) begin
            cyc("ar_3",   0, 0, 0,   0, 0, 1, 1,    2'b01, 16'd3,    0, 1, 0);
            cyc("ar_2",   0, 0, 0,   0, 0, 1, 1,    2'b01, 16'd2,    0, 1, 0);
            cyc("ar_1",   0, 0, 0,   0, 0, 1, 1,    2'b01, 16'd1,    0, 1, 0);
            cyc("ar_rl",  0, 0, 0,   0, 0, 1, 1,    2'b01, 16'd4,    1, 1, 0);
        end
        cyc("ar_3b",      0, 0, 0,   0, 0, 1, 1,    2'b01, 16'd3,    0, 1, 0);
        cyc("ar_en0",     0, 0, 0,   0, 0, 0, 1,    2'b01, 16'd3,    0, 1, 0);
        cyc("ar_en0",     0, 0, 0,   0, 0, 0, 1,    2'b01, 16'd3,    0, 1, 0);
        cyc("ar_2b",      0, 0, 0,   0, 0, 1, 1,    2'b01, 16'd2,    0, 1, 0);

        // wrap
        cyc("wr_load",    0, 1, 3,   0, 0, 0, 5,    2'b10, 16'd3,    0, 0, 0);
        cyc("wr_start",   0, 0, 0,   1, 0, 1, 5,    2'b10, 16'd3,    0, 1, 0);
        cyc("wr_fffe",    0, 0, 0,   0, 0, 1, 5,    2'b10, 16'hFFFE, 1, 1, 0);
        cyc("wr_fff9",    0, 0, 0,   0, 0, 1, 5,    2'b10, 16'hFFF9, 0, 1, 0);
        cyc("wr_load5",   0, 1, 5,   0, 0, 0, 5,    2'b10, 16'd5,    0, 0, 0);
        cyc("wr_start5",  0, 0, 0,   1, 0, 0, 5,    2'b10, 16'd5,    0, 1, 0);
        cyc("wr_zero",    0, 0, 0,   0, 0, 1, 5,    2'b10, 16'd0,    0, 1, 0);
        cyc("wr_fffb",    0, 0, 0,   0, 0, 1, 5,    2'b10, 16'hFFFB, 1, 1, 0);

        // priority
        cyc("pr_ldst",    0, 1, 7,   1, 0, 1, 1,    2'b00, 16'd7,    0, 0, 0);
        cyc("pr_load10",  0, 1, 10,  0, 0, 0, 1,    2'b00, 16'd10,   0, 0, 0);
        cyc("pr_start",   0, 0, 0,   1, 0, 1, 1,    2'b00, 16'd10,   0, 1, 0);
        cyc("pr_9",       0, 0, 0,   0, 0, 1, 1,    2'b00, 16'd9,    0, 1, 0);
        cyc("pr_stop",    0, 0, 0,   1, 1, 1, 1,    2'b00, 16'd9,    0, 0, 0);
        cyc("pr_idle",    0, 0, 0,   0, 0, 1, 1,    2'b00, 16'd9,    0, 0, 0);
        cyc("pr_resume",  0, 0, 0,   1, 0, 1, 1,    2'b00, 16'd9,    0, 1, 0);
        cyc("pr_8",       0, 0, 0,   0, 0, 1, 1,    2'b00, 16'd8,    0, 1, 0);

        // mode 11 behaves as one-shot
        cyc("m3_load",    0, 1, 2,   0, 0, 0, 1,    2'b11, 16'd2,    0, 0, 0);
        cyc("m3_start",   0, 0, 0,   1, 0, 1, 1,    2'b11, 16'd2,    0, 1, 0);
        cyc("m3_1",       0, 0, 0,   0, 0, 1, 1,    2'b11, 16'd1,    0, 1, 0);
        cyc("m3_0",       0, 0, 0,   0, 0, 1, 1,    2'b11, 16'd0,    1, 0, 1);

        // zero step
        cyc("zs_load",    0, 1, 0,   0, 0, 0, 0,    2'b00, 16'd0,    0, 0, 0);
        cyc("zs_start",   0, 0, 0,   1, 0, 1, 0,    2'b00, 16'd0,    0, 1, 0);
        for (int i = 0; i < 5; i++)
            cyc("zs_hold", 0, 0, 0,  0, 0, 1, 0,    2'b00, 16'd0,    0, 1, 0);
        cyc("zs_step1",   0, 0, 0,   0, 0, 1, 1,    2'b00, 16'd0,    1, 0, 1);
        cyc("zs_done",    0, 0, 0,   0, 0, 1, 1,    2'b00, 16'd0,    0, 0, 1);

        // auto-reload with reload value zero: tc every enabled cycle
        cyc("az_load",    0, 1, 0,   0, 0, 0, 1,    2'b01, 16'd0,    0, 0, 0);
        cyc("az_start",   0, 0, 0,   1, 0, 1, 1,    2'b01, 16'd0,    0, 1, 0);
        cyc("az_tc1",     0, 0, 0,   0, 0, 1, 1,    2'b01, 16'd0,    1, 1, 0);
        cyc("az_tc2",     0, 0, 0,   0, 0, 1, 1,    2'b01, 16'd0,    1, 1, 0);
        cyc("az_en0",     0, 0, 0,   0, 0, 0, 1,    2'b01, 16'd0,    0, 1, 0);

        check("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
